// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has fixed priority; mul/div results queue in a FIFO.
// Optional build macro WB_BYPASS_EN lets a mul/div result write the RF in its accept cycle when the port is idle.
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0] pipe_wd,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [ADDR_W-1:0] md_rd,
    input  logic [DATA_W-1:0] md_wd,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_wd3,
    output logic              md_pending,
    output logic [ADDR_W-1:0] md_pend_rd,
    output logic              wb_stall_req
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] STV_SAT  = STV_W'(STARVE_MAX);

    logic [ADDR_W-1:0] fifo_rd [DEPTH];
    logic [DATA_W-1:0] fifo_wd [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [STV_W-1:0]  starve_cnt;
    logic [STV_W-1:0]  starve_next;
    logic              pipe_slot_busy;
    logic              fifo_empty;
    logic              accept;
    logic              push;
    logic              pop;
    logic              bypass;

    assign pipe_slot_busy = pipe_we && (pipe_rd != '0);
    assign fifo_empty     = (count == '0);

    // md handshake: a result transfers on the rising edge where md_valid && md_ready; md_valid
    // may not depend on md_ready, and md_ready depends only on occupancy (never on a same-cycle pop).
    assign md_ready = rst_n && (count < FULL_CNT);
    assign accept   = md_valid && md_ready;
    assign pop      = rst_n && !pipe_slot_busy && !fifo_empty;

`ifdef WB_BYPASS_EN
    assign bypass = rst_n && fifo_empty && !pipe_slot_busy && md_valid && (md_rd != '0);
`else
    assign bypass = 1'b0;
`endif

    // x0 results are acknowledged but never stored.
    assign push = accept && (md_rd != '0) && !bypass;

    assign md_pending = !fifo_empty;
    assign md_pend_rd = fifo_empty ? '0 : fifo_rd[rd_ptr];

    always_comb begin
        rf_we  = 1'b0;
        rf_a3  = '0;
        rf_wd3 = '0;
        if (rst_n && pipe_slot_busy) begin
            rf_we  = 1'b1;
            rf_a3  = pipe_rd;
            rf_wd3 = pipe_wd;
        end else if (pop) begin
            rf_we  = 1'b1;
            rf_a3  = fifo_rd[rd_ptr];
            rf_wd3 = fifo_wd[rd_ptr];
        end else if (bypass) begin
            rf_we  = 1'b1;
            rf_a3  = md_rd;
            rf_wd3 = md_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr] <= md_rd;
            fifo_wd[wr_ptr] <= md_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Starvation counts only cycles where a queued result lost the port to the pipeline.
    always_comb begin
        starve_next = starve_cnt;
        if (pop || fifo_empty)
            starve_next = '0;
        else if (pipe_slot_busy && (starve_cnt != STV_SAT))
            starve_next = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt   <= '0;
            wb_stall_req <= 1'b0;
        end else begin
            starve_cnt   <= starve_next;
            wb_stall_req <= (starve_next == STV_SAT);
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based model predicts each cycle's RF write and status outputs.
module tb_wb_port_arbiter;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              pipe_we = 1'b0;
  logic [ADDR_W-1:0] pipe_rd = '0;
  logic [DATA_W-1:0] pipe_wd = '0;
  logic              md_valid = 1'b0;
  logic              md_ready;
  logic [ADDR_W-1:0] md_rd = '0;
  logic [DATA_W-1:0] md_wd = '0;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_a3;
  logic [DATA_W-1:0] rf_wd3;
  logic              md_pending;
  logic [ADDR_W-1:0] md_pend_rd;
  logic              wb_stall_req;

  wb_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_wd(md_wd),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
    .md_pending(md_pending), .md_pend_rd(md_pend_rd), .wb_stall_req(wb_stall_req)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] wd;
  } wr_t;

  typedef struct packed {
    logic              we;
    logic              ready;
    logic              pending;
    logic [ADDR_W-1:0] pend_rd;
    logic              stall;
  } flags_t;

  // scoreboard queues and reference model state
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  flags_t flag_q[$];
  wr_t    model_q[$];
  int     blocked = 0;
  int     errors = 0;
  int     checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs, predict the outcome, advance past the next rising edge
  task automatic drive(input logic pwe, input logic [ADDR_W-1:0] prd, input logic [DATA_W-1:0] pwd,
                       input logic mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] mwd);
    flags_t f;
    wr_t    w;
    logic   busy, popped, byp;
    pipe_we = pwe; pipe_rd = prd; pipe_wd = pwd;
    md_valid = mv; md_rd = mrd; md_wd = mwd;
    busy      = pwe && (prd != 0);
    f.ready   = model_q.size() < DEPTH;
    f.pending = model_q.size() != 0;
    f.pend_rd = f.pending ? model_q[0].rd : '0;
    f.stall   = blocked >= STARVE_MAX;
    f.we      = 1'b0;
    popped    = 1'b0;
    byp       = 1'b0;
    if (busy) begin
      f.we = 1'b1;
      exp_q.push_back({prd, pwd});
    end else if (model_q.size() != 0) begin
      w = model_q.pop_front();
      popped = 1'b1;
      f.we = 1'b1;
      exp_q.push_back(w);
    end
`ifdef WB_BYPASS_EN
    else if (mv && mrd != 0) begin
      byp = 1'b1;
      f.we = 1'b1;
      exp_q.push_back({mrd, mwd});
    end
`endif
    if (mv && f.ready && mrd != 0 && !byp) model_q.push_back('{rd: mrd, wd: mwd});
    if (popped || !f.pending) blocked = 0;
    else blocked++;
    flag_q.push_back(f);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // reset with md_valid and pipe_we asserted; everything queued is discarded
  task automatic reset_check(input string tag);
    rst_n = 1'b0;
    pipe_we = 1'b1; pipe_rd = 5'd5; md_valid = 1'b1; md_rd = 5'd9;
    #1;
    check({tag, "_md_ready"}, md_ready, 0);
    check({tag, "_rf_we"}, rf_we, 0);
    check({tag, "_rf_a3"}, rf_a3, 0);
    check({tag, "_md_pending"}, md_pending, 0);
    check({tag, "_md_pend_rd"}, md_pend_rd, 0);
    check({tag, "_stall"}, wb_stall_req, 0);
    model_q.delete();
    exp_q.delete();
    flag_q.delete();
    blocked = 0;
    @(negedge clk);
    @(negedge clk);
    pipe_we = 1'b0; md_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check({tag, "_md_ready_release"}, md_ready, 1);
    @(posedge clk);
    #1;
  endtask

  // monitor: compare on the falling edge, away from the committing edge
  flags_t                   mf;
  logic [ADDR_W+DATA_W-1:0] me;
  always @(negedge clk) begin
    if (rst_n && flag_q.size() != 0) begin
      mf = flag_q.pop_front();
      check("rf_we", rf_we, mf.we);
      check("md_ready", md_ready, mf.ready);
      check("md_pending", md_pending, mf.pending);
      check("md_pend_rd", md_pend_rd, mf.pend_rd);
      check("wb_stall_req", wb_stall_req, mf.stall);
      if (mf.we) begin
        me = exp_q.pop_front();
        if (rf_we) begin
          check("rf_a3", rf_a3, me[DATA_W +: ADDR_W]);
          check("rf_wd3", rf_wd3, me[DATA_W-1:0]);
        end
      end else if (!rf_we) begin
        check("rf_a3_idle", rf_a3, 0);
        check("rf_wd3_idle", rf_wd3, 0);
      end
    end
  end

  initial begin
    int pressure;
    logic pwe;
    logic [ADDR_W-1:0] prd, mrd;

    reset_check("reset");

    // pipeline write at zero latency; x0 write suppressed
    drive(1'b1, 5'd5, 32'h11, 1'b0, '0, '0);
    drive(1'b1, 5'd0, 32'h22, 1'b0, '0, '0);

    // lone mul/div result on an idle port
    drive(1'b0, '0, '0, 1'b1, 5'd7, 32'hABCD);
    idle(3);

    // starvation: pipeline busy every cycle, two results queued
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd3, 32'h3333);
    drive(1'b1, 5'd2, 32'h101, 1'b1, 5'd4, 32'h4444);
    for (int i = 0; i < 6; i++) drive(1'b1, 5'(i + 8), $urandom, 1'b1, 5'd20, 32'hDEAD);
    idle(3);

    // full FIFO: a pop and md_valid in the same cycle must not accept
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA0);
    drive(1'b1, 5'd1, 32'h2, 1'b1, 5'd11, 32'hB0);
    drive(1'b0, '0, '0, 1'b1, 5'd12, 32'hC0);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    idle(2);

    // x0 result accepted and dropped, then reset with two results queued
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF);
    idle(1);
    drive(1'b1, 5'd6, 32'h6, 1'b1, 5'd13, 32'hD0);
    drive(1'b1, 5'd6, 32'h7, 1'b1, 5'd14, 32'hE0);
    reset_check("midreset");
    idle(2);

    // randomized traffic with alternating pipeline pressure; the pipeline honours the stall request
    pressure = 30;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) pressure = ($urandom_range(0, 1) == 0) ? 30 : 95;
      pwe = (blocked >= STARVE_MAX) ? 1'b0 : ($urandom_range(0, 99) < pressure);
      prd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drive(pwe, prd, $urandom, $urandom_range(0, 1) == 1, mrd, $urandom);
    end
    idle(4);

    @(negedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    check("model_q_drained", model_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
